// File: rtl/uart_pkg.sv
// Shared defaults for the UART shift-register datapath.
package uart_pkg;

    localparam int UART_WIDTH_DEF = 9;
    localparam bit LSB_FIRST_DEF  = 1'b1;

endpackage : uart_pkg

// File: rtl/shift_register_framed.sv
// Serial<->parallel shift register with a per-frame bit counter, shared by the
// UART RX and TX paths; done pulses one cycle after the WIDTH-th shift.
module shift_register_framed
    import uart_pkg::*;
#(
    parameter int WIDTH     = UART_WIDTH_DEF,
    parameter bit LSB_FIRST = LSB_FIRST_DEF,
    localparam int CW       = $clog2(WIDTH + 1)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic [WIDTH-1:0] din,
    input  logic             start,
    input  logic             shift_en,
    input  logic             sin,
    output logic [WIDTH-1:0] q,
    output logic             sout,
    output logic [CW-1:0]    count,
    output logic             busy,
    output logic             done
);

    if (WIDTH < 2 || WIDTH > 32) begin : g_width_check
        $error("shift_register_framed: WIDTH must be within 2..32");
    end

    logic [WIDTH-1:0] q_q, q_d;
    logic [WIDTH-1:0] shifted;
    logic [CW-1:0]    count_q, count_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;

    // Shift direction decides both where sin enters and which end drives sout.
    if (LSB_FIRST) begin : g_lsb_first
        assign shifted = {sin, q_q[WIDTH-1:1]};
        assign sout    = q_q[0];
    end else begin : g_msb_first
        assign shifted = {q_q[WIDTH-2:0], sin};
        assign sout    = q_q[WIDTH-1];
    end

    always_comb begin
        q_d     = q_q;
        count_d = count_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        if (load) begin
            q_d     = din;
            count_d = '0;
            busy_d  = 1'b1;
        end else if (start) begin
            count_d = '0;
            busy_d  = 1'b1;
        end else if (shift_en && busy_q) begin
            q_d     = shifted;
            count_d = count_q + CW'(1);
            if (count_q == CW'(WIDTH - 1)) begin
                busy_d = 1'b0;
                done_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            q_q     <= '0;
            count_q <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            q_q     <= q_d;
            count_q <= count_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign q     = q_q;
    assign count = count_q;
    assign busy  = busy_q;
    assign done  = done_q;

endmodule : shift_register_framed

// File: tb/tb_shift_register_framed.sv
// Drives an LSB-first 9-bit and an MSB-first 8-bit instance with shared controls
// and compares both against a word-level model of the framing rules.
module tb_shift_register_framed;

    logic       clk = 1'b0;
    logic       reset, load, start, shift_en, sin;
    logic [8:0] din_a, q_a;
    logic [7:0] din_b, q_b;
    logic [3:0] count_a, count_b;
    logic       sout_a, busy_a, done_a;
    logic       sout_b, busy_b, done_b;

    always #5 clk = ~clk;

    shift_register_framed #(.WIDTH(9), .LSB_FIRST(1'b1)) dut_a (
        .clk(clk), .reset(reset), .load(load), .din(din_a), .start(start),
        .shift_en(shift_en), .sin(sin), .q(q_a), .sout(sout_a),
        .count(count_a), .busy(busy_a), .done(done_a)
    );

    shift_register_framed #(.WIDTH(8), .LSB_FIRST(1'b0)) dut_b (
        .clk(clk), .reset(reset), .load(load), .din(din_b), .start(start),
        .shift_en(shift_en), .sin(sin), .q(q_b), .sout(sout_b),
        .count(count_b), .busy(busy_b), .done(done_b)
    );

    // Word-level model: index 0 = dut_a, index 1 = dut_b
    int unsigned m_w[2]   = '{9, 8};
    bit          m_lsb[2] = '{1'b1, 1'b0};
    int unsigned m_q[2], m_cnt[2];
    bit          m_busy[2], m_done[2];

    int n_checks = 0;
    int n_pass   = 0;
    int done_pulses_a;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    task automatic model_reset();
        for (int i = 0; i < 2; i++) begin
            m_q[i] = 0; m_cnt[i] = 0; m_busy[i] = 1'b0; m_done[i] = 1'b0;
        end
    endtask

    task automatic model_edge(input bit l, input bit s, input bit e, input bit b,
                              input int unsigned da, input int unsigned db);
        for (int i = 0; i < 2; i++) begin
            int unsigned mask = (1 << m_w[i]) - 1;
            m_done[i] = 1'b0;
            if (l) begin
                m_q[i] = ((i == 0) ? da : db) & mask;
                m_cnt[i] = 0; m_busy[i] = 1'b1;
            end else if (s) begin
                m_cnt[i] = 0; m_busy[i] = 1'b1;
            end else if (e && m_busy[i]) begin
                if (m_lsb[i]) m_q[i] = (m_q[i] / 2) + (int'(b) << (m_w[i] - 1));
                else          m_q[i] = (m_q[i] * 2 + int'(b)) & mask;
                m_cnt[i]++;
                if (m_cnt[i] == m_w[i]) begin
                    m_busy[i] = 1'b0; m_done[i] = 1'b1;
                end
            end
        end
    endtask

    task automatic check_all(input string t);
        check({t, ".q_a"},    32'(q_a),     m_q[0]);
        check({t, ".cnt_a"},  32'(count_a), m_cnt[0]);
        check({t, ".busy_a"}, 32'(busy_a),  32'(m_busy[0]));
        check({t, ".done_a"}, 32'(done_a),  32'(m_done[0]));
        check({t, ".sout_a"}, 32'(sout_a),  m_q[0] % 2);
        check({t, ".q_b"},    32'(q_b),     m_q[1]);
        check({t, ".cnt_b"},  32'(count_b), m_cnt[1]);
        check({t, ".busy_b"}, 32'(busy_b),  32'(m_busy[1]));
        check({t, ".done_b"}, 32'(done_b),  32'(m_done[1]));
        check({t, ".sout_b"}, 32'(sout_b),  (m_q[1] >> 7) % 2);
    endtask

    // Called at a falling edge; returns at the next falling edge.
    task automatic cycle(input string t, input bit l, input bit s, input bit e, input bit b,
                         input logic [8:0] da, input logic [7:0] db);
        load = l; start = s; shift_en = e; sin = b; din_a = da; din_b = db;
        @(posedge clk);
        model_edge(l, s, e, b, 32'(da), 32'(db));
        #1;
        if (done_a) done_pulses_a++;
        check_all(t);
        $display("[%0t] %s load=%0b start=%0b shift=%0b sin=%0b q_a=%03h cnt_a=%0d q_b=%02h cnt_b=%0d",
                 $time, t, l, s, e, b, q_a, count_a, q_b, count_b);
        @(negedge clk);
    endtask

    initial begin
        logic [8:0] rx_bits;
        logic [7:0] tx_word;
        reset = 1'b1; load = 1'b0; start = 1'b0; shift_en = 1'b0; sin = 1'b0;
        din_a = '0; din_b = '0;
        model_reset();
        #1;
        check_all("reset");
        @(negedge clk);
        reset = 1'b0;

        // Asynchronous reset in the middle of a frame
        cycle("t1.load", 1, 0, 0, 0, 9'h1A5, 8'hA5);
        for (int i = 0; i < 3; i++) cycle("t1.shift", 0, 0, 1, 1, '0, '0);
        reset = 1'b1;
        #1;
        model_reset();
        check_all("t1.async_rst");
        @(negedge clk);
        reset = 1'b0;

        // RX frame, LSB first: sin sequence 1,0,1,0,0,1,1,0,1
        rx_bits = 9'b1_0110_0101;
        done_pulses_a = 0;
        cycle("t2.start", 0, 1, 0, 0, '0, '0);
        for (int i = 0; i < 9; i++) cycle("t2.shift", 0, 0, 1, rx_bits[i], '0, '0);
        check("t2.q_word", 32'(q_a), 32'h165);
        check("t2.count9", 32'(count_a), 32'd9);
        check("t2.done_once", 32'(done_pulses_a), 32'd1);
        cycle("t2.after", 0, 0, 0, 0, '0, '0);

        // TX frame, MSB first on the 8-bit instance
        tx_word = 8'hC3;
        cycle("t3.load", 1, 0, 0, 0, 9'h000, tx_word);
        for (int i = 0; i < 8; i++) begin
            check("t3.sout_bit", 32'(sout_b), 32'(tx_word[7-i]));
            cycle("t3.shift", 0, 0, 1, 0, '0, '0);
        end
        check("t3.busy_low", 32'(busy_b), 32'd0);

        // Collisions: load and start both beat shift_en
        cycle("t4.load_shift", 1, 0, 1, 1, 9'h0FF, 8'h5A);
        check("t4.q_ff", 32'(q_a), 32'h0FF);
        check("t4.cnt0", 32'(count_a), 32'd0);
        cycle("t4.shift", 0, 0, 1, 0, '0, '0);
        cycle("t4.start_shift", 0, 1, 1, 1, '0, '0);
        check("t4.start_cnt0", 32'(count_a), 32'd0);

        // Finish the frame, then shifts while idle must be ignored
        for (int i = 0; i < 9; i++) cycle("t5.fill", 0, 0, 1, 1, '0, '0);
        for (int i = 0; i < 5; i++) cycle("t5.idle", 0, 0, 1, i[0], '0, '0);
        check("t5.idle_cnt", 32'(count_a), 32'd9);

        // Abort a frame with a second start
        done_pulses_a = 0;
        cycle("t6.start", 0, 1, 0, 0, '0, '0);
        for (int i = 0; i < 4; i++) cycle("t6.shift", 0, 0, 1, 0, '0, '0);
        cycle("t6.restart", 0, 1, 0, 0, '0, '0);
        check("t6.busy", 32'(busy_a), 32'd1);
        for (int i = 0; i < 9; i++) cycle("t6.shift2", 0, 0, 1, 1, '0, '0);
        check("t6.done_once", 32'(done_pulses_a), 32'd1);

        // Randomized traffic
        for (int n = 0; n < 400; n++) begin
            bit rl, rs, re;
            rl = ($urandom_range(99, 0) < 4);
            rs = ($urandom_range(99, 0) < 4);
            re = ($urandom_range(99, 0) < 60);
            cycle("rand", rl, rs, re, 1'($urandom), 9'($urandom), 8'($urandom));
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule : tb_shift_register_framed
